// File: rtl/count_ctrl_pkg.sv
// Shared types and constants for the button-driven
// count enable path.
package count_ctrl_pkg;

  localparam int unsigned TIMER_W = 8;

  localparam int unsigned CYC_MIN = 1;
  localparam int unsigned CYC_MAX = 255;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } btn_state_t;

  function automatic logic cyc_ok(int unsigned v);
    return (v >= CYC_MIN) && (v <= CYC_MAX);
  endfunction

endpackage

// File: rtl/count_enable_gen_if.sv
// Button in, enable/pressed out bundle between the
// push-button front end and its consumer.
interface count_enable_gen_if;

  logic button_in;
  logic repeat_en;
  logic enable;
  logic pressed;

  modport master (
    output button_in,
    output repeat_en,
    input  enable,
    input  pressed
  );

  modport slave (
    input  button_in,
    input  repeat_en,
    output enable,
    output pressed
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with synchronous
// active-high reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] s1_q;
  logic [WIDTH-1:0] s2_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/count_enable_gen.sv
// Debounced push-button to single-cycle enable pulses,
// with optional auto-repeat while held.
module count_enable_gen
  import count_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16
) (
  input  logic              clock,
  input  logic              reset,
  count_enable_gen_if.slave bus
);

  if (!cyc_ok(DEBOUNCE_CYCLES)) begin : g_bad_deb
    $error("DEBOUNCE_CYCLES out of range 1..255");
  end
  if (!cyc_ok(REPEAT_DELAY)) begin : g_bad_dly
    $error("REPEAT_DELAY out of range 1..255");
  end
  if (!cyc_ok(REPEAT_PERIOD)) begin : g_bad_per
    $error("REPEAT_PERIOD out of range 1..255");
  end

  localparam logic [TIMER_W-1:0] DEB_LAST =
    TIMER_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DLY_LAST =
    TIMER_W'(REPEAT_DELAY - 1);
  localparam logic [TIMER_W-1:0] PER_LAST =
    TIMER_W'(REPEAT_PERIOD - 1);

  logic s2;

  sync_2ff #(
    .WIDTH (1)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (bus.button_in),
    .q_o   (s2)
  );

  btn_state_t         state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [TIMER_W-1:0] timer_inc;
  logic               enable_q, enable_d;
  logic               pressed_q, pressed_d;

  assign timer_inc = (timer_q == '1) ? timer_q
                                     : timer_q + 1'b1;

  // A falling s2 is checked first in every state so a
  // release always beats a pulse on the same edge.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_inc;
    enable_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        timer_d = '0;
        if (s2) state_d = DEB_PRESS;
      end
      DEB_PRESS: begin
        if (!s2) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d  = HELD;
          timer_d  = '0;
          enable_d = 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_d = DEB_RELEASE;
          timer_d = '0;
        end else if (bus.repeat_en &&
                     timer_q == DLY_LAST) begin
          state_d  = REPEAT;
          timer_d  = '0;
          enable_d = 1'b1;
        end
      end
      REPEAT: begin
        if (!s2) begin
          state_d = DEB_RELEASE;
          timer_d = '0;
        end else if (!bus.repeat_en) begin
          timer_d = '0;
        end else if (timer_q == PER_LAST) begin
          timer_d  = '0;
          enable_d = 1'b1;
        end
      end
      DEB_RELEASE: begin
        if (s2) begin
          state_d = HELD;
          timer_d = '0;
        end else if (timer_q == DEB_LAST) begin
          state_d = IDLE;
          timer_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  assign pressed_d = (state_d == HELD)   ||
                     (state_d == REPEAT) ||
                     (state_d == DEB_RELEASE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      enable_q  <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      enable_q  <= enable_d;
      pressed_q <= pressed_d;
    end
  end

  assign bus.enable  = enable_q;
  assign bus.pressed = pressed_q;

endmodule
